// File: rtl/wpat_seq_gen_pkg.sv
// Shared encodings for the pattern sequencer: source modes, FSM states and
// the LFSR feedback polynomial.
package wpat_seq_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_CONST = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/wpat_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load and step enable.
module wpat_lfsr8
  import wpat_seq_gen_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     q <= SEED;
    else if (load) q <= SEED;
    else if (en)   q <= lfsr_step(q);
  end

endmodule

// File: rtl/wpat_seq_gen.sv
// Burst pattern generator feeding the legacy compare/register datapath.
// Handshake: out_vld marks a beat; hold=1 from downstream keeps the current beat on the outputs unchanged.
module wpat_seq_gen
  import wpat_seq_gen_pkg::*;
#(
  parameter int         AW        = 4,
  parameter int         CNT_W     = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [7:0]       const_val,
  input  logic             hold,
  output logic [AW-1:0]    out_in0,
  output logic [7:0]       out_in1,
  output logic [4:0]       out_wpat1,
  output logic [3:0]       out_wpat2,
  output logic             out_vld,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  mode_t            mode_q;
  logic [CNT_W-1:0] len_q, cnt_q;
  logic [7:0]       d_q, d_next, d_first, lfsr_q, pattern;
  logic             accept, issue;

  assign fsm_state = state_q;

  // cnt_q counts beats already issued, so cnt_q==len_q means the burst is spent.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          accept  = 1'b1;
          state_d = (burst_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (stop)                state_d = ST_DONE;
        else if (hold)           state_d = ST_HOLD;
        else if (cnt_q == len_q) state_d = ST_DONE;
        else begin
          issue   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pattern = (mode_q == MODE_LFSR) ? lfsr_q : d_q;
    case (mode_q)
      MODE_INCR: d_next = d_q + 8'd1;
      MODE_WALK: d_next = {d_q[6:0], d_q[7]};
      default:   d_next = d_q;
    endcase
    case (mode_t'(mode))
      MODE_WALK:  d_first = 8'h01;
      MODE_CONST: d_first = const_val;
      default:    d_first = 8'h00;
    endcase
  end

  wpat_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .load (accept),
    .en   (issue && (mode_q == MODE_LFSR)),
    .q    (lfsr_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_INCR;
      len_q     <= '0;
      cnt_q     <= '0;
      d_q       <= '0;
      out_in0   <= '0;
      out_in1   <= '0;
      out_wpat1 <= '0;
      out_wpat2 <= '0;
      out_vld   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ST_RUN) || (state_d == ST_HOLD);
      done    <= (state_d == ST_DONE);
      if (accept) begin
        mode_q <= mode_t'(mode);
        len_q  <= burst_len;
        cnt_q  <= '0;
        d_q    <= d_first;
      end
      if (issue) begin
        out_in0   <= pattern[AW-1:0];
        out_in1   <= pattern;
        out_wpat1 <= pattern[7:3];
        out_wpat2 <= cnt_q[3:0];
        out_vld   <= 1'b1;
        cnt_q     <= cnt_q + CNT_ONE;
        d_q       <= d_next;
      end else if ((state_d == ST_DONE) || (state_d == ST_IDLE)) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wpat_seq_gen.sv
// Directed bench for wpat_seq_gen: one task per scenario, inputs driven and
// outputs sampled on the falling clock edge.
module tb_wpat_seq_gen;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] burst_len = 8'd0, const_val = 8'd0;
  logic [3:0] out_in0;
  logic [7:0] out_in1;
  logic [4:0] out_wpat1;
  logic [3:0] out_wpat2;
  logic       out_vld, busy, done;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wpat_seq_gen #(.AW(4), .CNT_W(8), .LFSR_SEED(8'hA5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .burst_len (burst_len),
    .const_val (const_val),
    .hold      (hold),
    .out_in0   (out_in0),
    .out_in1   (out_in1),
    .out_wpat1 (out_wpat1),
    .out_wpat2 (out_wpat2),
    .out_vld   (out_vld),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] len, input logic [7:0] cv);
    mode = m; burst_len = len; const_val = cv; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_in1 !== 8'h00 ||
        out_in0 !== 4'h0 || out_wpat1 !== 5'h00 || out_wpat2 !== 4'h0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset: vld=%b busy=%b done=%b in1=%h in0=%h w1=%h w2=%h st=%0d, expected all zero",
               out_vld, busy, done, out_in1, out_in0, out_wpat1, out_wpat2, fsm_state);
    end
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_incr();
    launch(2'd0, 8'd4, 8'h00);
    checks++;
    if (busy !== 1'b1 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL incr_launch: busy=%b vld=%b, expected busy=1 vld=0", busy, out_vld);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_vld !== 1'b1 || out_in1 !== 8'(i) || out_wpat2 !== 4'(i) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL incr_beat%0d: vld=%b in1=%h w2=%h busy=%b done=%b, expected 1 %h %h 1 0",
                 i, out_vld, out_in1, out_wpat2, busy, done, 8'(i), 4'(i));
      end
    end
    step();
    checks++;
    if (out_vld !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL incr_end: vld=%b done=%b busy=%b, expected 0 1 0", out_vld, done, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL incr_idle: done=%b st=%0d, expected 0 0", done, fsm_state);
    end
  endtask

  task automatic test_lfsr();
    logic [7:0] exp_v [3] = '{8'hA5, 8'h4A, 8'h95};
    logic [7:0] e;
    launch(2'd1, 8'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_v[i];
      checks++;
      if (out_vld !== 1'b1 || out_in1 !== e || out_in0 !== e[3:0] || out_wpat1 !== e[7:3]) begin
        errors++;
        $display("FAIL lfsr_beat%0d: vld=%b in1=%h in0=%h w1=%h, expected 1 %h %h %h",
                 i, out_vld, out_in1, out_in0, out_wpat1, e, e[3:0], e[7:3]);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL lfsr_end: done=%b vld=%b, expected 1 0", done, out_vld);
    end
    step();
  endtask

  task automatic test_walk_hold();
    logic [7:0] exp_v [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    launch(2'd2, 8'd10, 8'h00);
    mode = 2'd0;
    burst_len = 8'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_vld !== 1'b1 || out_in1 !== exp_v[i] || out_wpat2 !== 4'(i)) begin
        errors++;
        $display("FAIL walk_beat%0d: vld=%b in1=%h w2=%h, expected 1 %h %h",
                 i, out_vld, out_in1, out_wpat2, exp_v[i], 4'(i));
      end
      if (i == 2) begin
        hold = 1'b1;
        for (int h = 0; h < 2; h++) begin
          step();
          checks++;
          if (out_vld !== 1'b1 || out_in1 !== 8'h04 || out_wpat2 !== 4'd2 || fsm_state !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL walk_hold%0d: vld=%b in1=%h w2=%h st=%0d busy=%b, expected 1 04 2 2 1",
                     h, out_vld, out_in1, out_wpat2, fsm_state, busy);
          end
        end
        hold = 1'b0;
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL walk_end: done=%b vld=%b, expected 1 0", done, out_vld);
    end
    step();
  endtask

  task automatic test_const_empty();
    launch(2'd3, 8'd2, 8'hF8);
    const_val = 8'h00;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_vld !== 1'b1 || out_in1 !== 8'hF8 || out_in0 !== 4'h8 || out_wpat1 !== 5'h1F) begin
        errors++;
        $display("FAIL const_beat%0d: vld=%b in1=%h in0=%h w1=%h, expected 1 f8 8 1f",
                 i, out_vld, out_in1, out_in0, out_wpat1);
      end
    end
    step();
    step();
    launch(2'd3, 8'd0, 8'hF8);
    checks++;
    if (out_vld !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: vld=%b done=%b busy=%b, expected 0 1 0", out_vld, done, busy);
    end
    step();
    checks++;
    if (out_vld !== 1'b0 || done !== 1'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL empty_after: vld=%b done=%b st=%0d, expected 0 0 0", out_vld, done, fsm_state);
    end
  endtask

  task automatic test_stop();
    launch(2'd0, 8'd20, 8'h00);
    for (int i = 0; i < 6; i++) begin
      start = (i == 2);
      step();
      checks++;
      if (out_vld !== 1'b1 || out_in1 !== 8'(i) || out_wpat2 !== 4'(i)) begin
        errors++;
        $display("FAIL stop_beat%0d: vld=%b in1=%h w2=%h, expected 1 %h %h",
                 i, out_vld, out_in1, out_wpat2, 8'(i), 4'(i));
      end
    end
    start = 1'b0;
    stop = 1'b1;
    hold = 1'b1;
    step();
    stop = 1'b0;
    hold = 1'b0;
    checks++;
    if (out_vld !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_end: vld=%b done=%b busy=%b, expected 0 1 0", out_vld, done, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL stop_idle: done=%b st=%0d, expected 0 0", done, fsm_state);
    end
    start = 1'b1;
    stop = 1'b1;
    burst_len = 8'd4;
    step();
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL start_stop_idle: busy=%b done=%b st=%0d, expected 0 0 0", busy, done, fsm_state);
    end
  endtask

  task automatic test_wrap();
    launch(2'd0, 8'd18, 8'h00);
    for (int i = 0; i < 18; i++) begin
      step();
      checks++;
      if (out_vld !== 1'b1 || out_in1 !== 8'(i) || out_wpat2 !== 4'(i % 16)) begin
        errors++;
        $display("FAIL wrap_beat%0d: vld=%b in1=%h w2=%h, expected 1 %h %h",
                 i, out_vld, out_in1, out_wpat2, 8'(i), 4'(i % 16));
      end
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end: done=%b, expected 1", done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    launch(2'd0, 8'd8, 8'h00);
    for (int i = 0; i < 3; i++) step();
    rstn = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b0 || busy !== 1'b0 || out_in1 !== 8'h00 || out_wpat2 !== 4'h0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL rst_async: vld=%b busy=%b in1=%h w2=%h st=%0d, expected all zero",
               out_vld, busy, out_in1, out_wpat2, fsm_state);
    end
    step();
    checks++;
    if (done !== 1'b0 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_nodone: done=%b vld=%b, expected 0 0", done, out_vld);
    end
    rstn = 1'b1;
    step();
    launch(2'd0, 8'd2, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_vld !== 1'b1 || out_in1 !== 8'(i)) begin
        errors++;
        $display("FAIL rst_restart%0d: vld=%b in1=%h, expected 1 %h", i, out_vld, out_in1, 8'(i));
      end
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart_end: done=%b, expected 1", done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_incr();
    test_lfsr();
    test_walk_hold();
    test_const_empty();
    test_stop();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
